mdu: RTL

Multiply/divide unit for the EX stage of the pipelined MIPS core, placed alongside the ALU and fed by the same forwarded SrcA/SrcB operands. It executes MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations, and MTHI/MTLO as single-cycle writes. It holds the architectural HI/LO registers and exposes them for MFHI/MFLO. A busy output lets the hazard unit stall dependent instructions in ID.

---
 rtl/mdu_pkg.sv | 62 ++++++
 rtl/mdu.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the MDUOp encodings used by the control decoder, the hazard unit and
// the MDU itself, the default busy latencies, and the arithmetic helpers that
// produce the 64-bit {HI,LO} result of a mult/div operation.
package mdu_pkg;

   typedef enum logic [2:0] {
      MDU_NONE  = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6
   } mdu_op_t;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // 32x32 -> 64 product. Extending both operands to 64 bits and keeping the
   // low 64 bits of the product gives the correct two's-complement result
   // for the signed case without relying on signed operator semantics.
   function automatic logic [63:0] mdu_mul(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic        sgn);
      logic [63:0] ea;
      logic [63:0] eb;
      ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
      eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
      return ea * eb;
   endfunction

   // Returns {remainder, quotient}. The signed case divides magnitudes and
   // fixes the signs afterwards, so 0x80000000 / -1 never overflows a signed
   // divider and yields quotient 0x80000000, remainder 0. A zero divisor
   // returns zeros; the caller discards that result anyway.
   function automatic logic [63:0] mdu_divmod(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic        sgn);
      logic        na;
      logic        nb;
      logic [31:0] ma;
      logic [31:0] mb;
      logic [31:0] q;
      logic [31:0] r;
      na = sgn & a[31];
      nb = sgn & b[31];
      ma = na ? (32'd0 - a) : a;
      mb = nb ? (32'd0 - b) : b;
      if (mb == 32'd0) begin
         q = 32'd0;
         r = 32'd0;
      end else begin
         q = ma / mb;
         r = ma % mb;
      end
      if (na ^ nb) q = 32'd0 - q;
      if (na)      r = 32'd0 - r;
      return {r, q};
   endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage.
// Executes MULT/MULTU/DIV/DIVU as fixed-latency operations and MTHI/MTLO as
// single-cycle writes; owns the architectural HI/LO registers.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   start        EX-stage instruction is an MDU operation
//   MDUOp[2:0]   operation select (see mdu_pkg::mdu_op_t)
//   SrcA[31:0]   rs operand
//   SrcB[31:0]   rt operand
//   busy         high while a mult/div is in flight
//   HI[31:0]     architectural HI register
//   LO[31:0]     architectural LO register
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no operation in flight; accepts mult/div and MTHI/MTLO
// ST_RUN  | result held in res_hi/res_lo, cnt counts down to commit
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  MDUOp,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   logic [31:0]      res_hi;
   logic [31:0]      res_lo;
   logic             res_vld;
   logic [31:0]      hi_q;
   logic [31:0]      lo_q;

   logic             load_op;
   logic             op_vld;
   logic [CNT_W-1:0] op_cycles;
   logic [63:0]      op_result;
   logic             commit;
   logic             wr_hi;
   logic             wr_lo;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      load_op   = 1'b0;
      op_vld    = 1'b0;
      op_cycles = '0;
      op_result = '0;
      commit    = 1'b0;
      wr_hi     = 1'b0;
      wr_lo     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               case (MDUOp)
                  MDU_MULT: begin
                     load_op   = 1'b1;
                     op_vld    = 1'b1;
                     op_cycles = CNT_W'(MULT_CYCLES);
                     op_result = mdu_mul(SrcA, SrcB, 1'b1);
                  end
                  MDU_MULTU: begin
                     load_op   = 1'b1;
                     op_vld    = 1'b1;
                     op_cycles = CNT_W'(MULT_CYCLES);
                     op_result = mdu_mul(SrcA, SrcB, 1'b0);
                  end
                  // Divide by zero still occupies the full latency; only the
                  // commit is suppressed so HI/LO keep their old values.
                  MDU_DIV: begin
                     load_op   = 1'b1;
                     op_vld    = (SrcB != 32'd0);
                     op_cycles = CNT_W'(DIV_CYCLES);
                     op_result = mdu_divmod(SrcA, SrcB, 1'b1);
                  end
                  MDU_DIVU: begin
                     load_op   = 1'b1;
                     op_vld    = (SrcB != 32'd0);
                     op_cycles = CNT_W'(DIV_CYCLES);
                     op_result = mdu_divmod(SrcA, SrcB, 1'b0);
                  end
                  MDU_MTHI: wr_hi = 1'b1;
                  MDU_MTLO: wr_lo = 1'b1;
                  default: ;
               endcase
               if (load_op) begin
                  state_nxt = ST_RUN;
                  cnt_nxt   = op_cycles;
               end
            end
         end
         ST_RUN: begin
            // start is ignored here: the hazard unit never issues while busy.
            if (cnt <= CNT_W'(1)) begin
               commit    = 1'b1;
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         res_hi  <= '0;
         res_lo  <= '0;
         res_vld <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (load_op) begin
            res_hi  <= op_result[63:32];
            res_lo  <= op_result[31:0];
            res_vld <= op_vld;
         end
         if (commit) begin
            if (res_vld) begin
               hi_q <= res_hi;
               lo_q <= res_lo;
            end
         end else begin
            if (wr_hi) hi_q <= SrcA;
            if (wr_lo) lo_q <= SrcA;
         end
      end
   end

   assign busy = (state == ST_RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule
